// File: rtl/bitmask_to_sorted_seq.sv
// bitmask_to_sorted_seq
//
// Expands a stream of presence bitmasks into a densely packed, ascending
// stream of IDs. Bit j of the k-th mask beat (with keep set) of a stream
// stands for ID k*NUM_ELEMENTS + j. Output beats are fully packed except the
// final beat of each stream, which may be partial or an empty terminator.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_STREAM | accepting mask beats, packing IDs into full output beats
// ST_FLUSH  | last beat overflowed; emit the pending remainder as last beat
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_data    presence mask, NUM_ELEMENTS bits
//   in_keep    beat carries a mask (0: beat contributes no IDs, base holds)
//   in_last    final beat of the stream
//   in_valid   input beat valid
//   in_ready   input beat accepted when high together with in_valid
//   out_data   NUM_ELEMENTS lanes of IDs, lane 0 lowest
//   out_keep   lane valid flags, always contiguous from lane 0
//   out_last   final beat of the stream
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
module bitmask_to_sorted_seq #(
  parameter int NUM_ELEMENTS = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_ELEMENTS-1:0]                 in_data,
  input  logic                                    in_keep,
  input  logic                                    in_last,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] out_data,
  output logic [NUM_ELEMENTS-1:0]                 out_keep,
  output logic                                    out_last,
  output logic                                    out_valid,
  input  logic                                    out_ready
);

  localparam int N  = NUM_ELEMENTS;
  localparam int CW = $clog2(NUM_ELEMENTS) + 1;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_FLUSH  = 1'b1
  } state_t;

  state_t        state_q;
  data_t         base_q;
  data_t         pend_q [N-1];
  logic [CW-1:0] cnt_q;

  logic          advance;
  logic          accept;
  logic [N-1:0]  mask;
  data_t         comb_ids [2*N];
  logic [CW:0]   tot;

  // Lanes below n set, the rest clear.
  function automatic logic [N-1:0] low_mask(input logic [CW:0] n);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = ((CW+1)'(i) < n);
    end
    return r;
  endfunction

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance && (state_q == ST_STREAM);
  assign accept   = in_valid && in_ready;
  assign mask     = in_keep ? in_data : '0;

  // Combined sequence: pending IDs first, then the new IDs compacted by
  // running popcount. Entries at and above tot stay zero, so lanes beyond
  // the valid count come out as zero without extra masking.
  always_comb begin
    int pos;
    for (int i = 0; i < 2*N; i++) begin
      comb_ids[i] = '0;
    end
    for (int i = 0; i < N-1; i++) begin
      if (CW'(i) < cnt_q) begin
        comb_ids[i] = pend_q[i];
      end
    end
    pos = int'(cnt_q);
    for (int j = 0; j < N; j++) begin
      if (mask[j]) begin
        comb_ids[pos] = base_q + DATA_WIDTH'(j);
        pos = pos + 1;
      end
    end
    tot = (CW+1)'(pos);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STREAM;
      base_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < N-1; i++) begin
        pend_q[i] <= '0;
      end
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_keep  <= '0;
      out_data  <= '0;
    end else if (advance) begin
      case (state_q)
        ST_STREAM: begin
          if (accept) begin
            if (in_keep) begin
              base_q <= base_q + DATA_WIDTH'(N);
            end
            if (in_last) begin
              // A new stream always restarts at ID 0.
              base_q <= '0;
              for (int i = 0; i < N; i++) begin
                out_data[i] <= comb_ids[i];
              end
              out_valid <= 1'b1;
              if (tot <= (CW+1)'(N)) begin
                out_keep <= low_mask(tot);
                out_last <= 1'b1;
                cnt_q    <= '0;
              end else begin
                out_keep <= '1;
                out_last <= 1'b0;
                for (int i = 0; i < N-1; i++) begin
                  pend_q[i] <= comb_ids[N+i];
                end
                cnt_q   <= CW'(tot - (CW+1)'(N));
                state_q <= ST_FLUSH;
              end
            end else if (tot >= (CW+1)'(N)) begin
              for (int i = 0; i < N; i++) begin
                out_data[i] <= comb_ids[i];
              end
              out_keep  <= '1;
              out_last  <= 1'b0;
              out_valid <= 1'b1;
              for (int i = 0; i < N-1; i++) begin
                pend_q[i] <= comb_ids[N+i];
              end
              cnt_q <= CW'(tot - (CW+1)'(N));
            end else begin
              // Not enough IDs for a full beat yet; keep accumulating.
              out_valid <= 1'b0;
              for (int i = 0; i < N-1; i++) begin
                pend_q[i] <= comb_ids[i];
              end
              cnt_q <= CW'(tot);
            end
          end else begin
            out_valid <= 1'b0;
          end
        end

        ST_FLUSH: begin
          for (int i = 0; i < N-1; i++) begin
            out_data[i] <= (CW'(i) < cnt_q) ? pend_q[i] : '0;
          end
          out_data[N-1] <= '0;
          out_keep      <= low_mask({1'b0, cnt_q});
          out_last      <= 1'b1;
          out_valid     <= 1'b1;
          cnt_q         <= '0;
          state_q       <= ST_STREAM;
        end

        default: state_q <= ST_STREAM;
      endcase
    end
  end

endmodule
